// File: rtl/prbs_checker.sv
// prbs_checker: self-seeding 8-bit PRBS checker with window lock supervision; err_cnt built only with PRBS_CHECKER_ERRCNT_EN
module prbs_checker #(
  parameter int WIN = 16,
  parameter int ERR_THRESH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tap,
  input  logic        bit_in,
  input  logic        bit_vld,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt
);
  localparam int WB = (WIN > 2) ? $clog2(WIN) : 1;
  localparam int EB = $clog2(ERR_THRESH + 1);
  typedef enum logic {SEED, CHECK} state_t;
  state_t state;
  logic [7:0] shadow, tap_q;
  logic [2:0] seed_cnt;
  logic [WB-1:0] win_bits;
  logic [EB-1:0] win_errs, errs_n;
  logic exp_bit, hit, mis;
  assign exp_bit = ^(shadow & tap_q);
  assign hit = bit_vld && state == CHECK;
  assign mis = hit && bit_in != exp_bit;
  assign errs_n = win_errs + EB'(mis);
  assign locked = state == CHECK;
  // seed from the line, then free-run the predictor and drop lock on too many errors per window
  always_ff @(posedge clk)
    if (reset) begin
      state <= SEED;
      shadow <= '0;
      seed_cnt <= '0;
      win_bits <= '0;
      win_errs <= '0;
      tap_q <= '0;
      err <= 1'b0;
    end else begin
      err <= mis;
      if (bit_vld && state == SEED) begin
        shadow <= {shadow[6:0], bit_in};
        seed_cnt <= seed_cnt + 3'd1;
        if (seed_cnt == 3'd7) begin
          state <= CHECK;
          tap_q <= tap;
          win_bits <= '0;
          win_errs <= '0;
        end
      end else if (hit) begin
        shadow <= {shadow[6:0], exp_bit};
        if (errs_n == EB'(ERR_THRESH)) begin
          state <= SEED;
          seed_cnt <= '0;
        end else if (win_bits == WB'(WIN - 1)) begin
          win_bits <= '0;
          win_errs <= '0;
        end else begin
          win_bits <= win_bits + WB'(1);
          win_errs <= errs_n;
        end
      end
    end
`ifdef PRBS_CHECKER_ERRCNT_EN
  logic [15:0] cnt_q;
  // saturating mismatch counter, clear wins over increment
  always_ff @(posedge clk)
    if (reset || clr_cnt) cnt_q <= '0;
    else if (mis && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  assign err_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: vector table, directed corner sequences and random stream against a history-based reference model
module tb_prbs_checker;
  localparam int WIN = 16;
  localparam int TH = 4;
`ifdef PRBS_CHECKER_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, bit_in = 1'b0, bit_vld = 1'b0, clr_cnt = 1'b0;
  logic [7:0] tap = 8'h00;
  logic locked, err;
  logic [15:0] err_cnt;
  prbs_checker #(.WIN(WIN), .ERR_THRESH(TH)) dut (
    .clk(clk), .reset(reset), .tap(tap), .bit_in(bit_in), .bit_vld(bit_vld),
    .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  typedef struct {bit r, b, v, c, e_err, e_lock; int e_cnt;} vec_t;
  vec_t tv[24];
  function automatic vec_t mk(bit r, bit b, bit v, bit c, bit e_err, bit e_lock, int e_cnt);
    vec_t x;
    x.r = r; x.b = b; x.v = v; x.c = c; x.e_err = e_err; x.e_lock = e_lock; x.e_cnt = e_cnt;
    return x;
  endfunction
  bit m_seed;
  int m_scnt, m_win, m_werr, m_cnt;
  bit m_err;
  bit m_hist[$];
  logic [7:0] m_tap;
  bit g_hist[$];
  logic [7:0] g_tap;
  function automatic bit parity(input bit h[$], input logic [7:0] t);
    bit p = 1'b0;
    for (int k = 0; k < 8; k++) if (t[k]) p ^= h[7 - k];
    return p;
  endfunction
  function automatic bit gen_next();
    bit b = parity(g_hist, g_tap);
    g_hist.push_back(b);
    void'(g_hist.pop_front());
    return b;
  endfunction
  task automatic model_step(input bit r, input bit b, input bit v, input bit c, input logic [7:0] t);
    bit p;
    m_err = 1'b0;
    if (r) begin
      m_seed = 1'b1; m_scnt = 0; m_tap = 8'h00; m_win = 0; m_werr = 0; m_cnt = 0;
      m_hist.delete();
      repeat (8) m_hist.push_back(1'b0);
    end else if (v && m_seed) begin
      m_hist.push_back(b);
      void'(m_hist.pop_front());
      m_scnt++;
      if (m_scnt == 8) begin m_seed = 1'b0; m_tap = t; m_win = 0; m_werr = 0; end
    end else if (v) begin
      p = parity(m_hist, m_tap);
      m_err = (b != p);
      m_hist.push_back(p);
      void'(m_hist.pop_front());
      if (m_err && m_cnt < 65535) m_cnt++;
      m_werr += int'(m_err);
      m_win++;
      if (m_werr == TH) begin m_seed = 1'b1; m_scnt = 0; end
      else if (m_win == WIN) begin m_win = 0; m_werr = 0; end
    end
    if (!r && c) m_cnt = 0;
  endtask
  task automatic drive(input string tag, input bit r, input bit v, input bit flip, input bit c);
    bit b;
    b = v ? (gen_next() ^ flip) : 1'($urandom);
    reset = r; bit_vld = v; bit_in = b; clr_cnt = c;
    model_step(r, b, v, c, tap);
    @(posedge clk);
    #1;
    chk({tag, ".err"}, int'(err), int'(m_err));
    chk({tag, ".locked"}, int'(locked), int'(!m_seed));
    chk({tag, ".err_cnt"}, int'(err_cnt), CNT_ON ? m_cnt : 0);
  endtask
  initial begin
    logic [7:0] sb;
    int errs;
    sb = 8'hB2;
    tap = 8'hB8;
    tv[0] = mk(1, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) tv[1 + j] = mk(0, sb[7 - j], 1, 0, 0, j == 7, 0);
    tv[9] = mk(0, 1, 1, 0, 0, 1, 0);
    tv[10] = mk(0, 1, 1, 0, 0, 1, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 1, 0);
    tv[12] = mk(1, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) tv[13 + j] = mk(0, sb[7 - j], 1, 0, 0, j == 7, 0);
    tv[21] = mk(0, 0, 1, 0, 1, 1, 1);
    tv[22] = mk(0, 1, 1, 1, 0, 1, 0);
    tv[23] = mk(0, 1, 1, 1, 1, 1, 0);
    for (int i = 0; i < 24; i++) begin
      reset = tv[i].r; bit_in = tv[i].b; bit_vld = tv[i].v; clr_cnt = tv[i].c;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.err", i), int'(err), int'(tv[i].e_err));
      chk($sformatf("vec%0d.locked", i), int'(locked), int'(tv[i].e_lock));
      chk($sformatf("vec%0d.err_cnt", i), int'(err_cnt), CNT_ON ? tv[i].e_cnt : 0);
    end
    g_tap = 8'hB8;
    tap = g_tap;
    sb = 8'($urandom_range(1, 255));
    for (int k = 0; k < 8; k++) g_hist.push_back(sb[k]);
    drive("ll.rst", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive("ll.seed", 0, 1, 0, 0);
    chk("ll.locked_after_seed", int'(locked), 1);
    for (int i = 0; i < 4; i++) drive("ll.inject", 0, 1, 1, 0);
    chk("ll.lost_err", int'(err), 1);
    chk("ll.lost_locked", int'(locked), 0);
    for (int i = 0; i < 7; i++) drive("ll.reseed", 0, 1, 0, 0);
    chk("ll.not_yet", int'(locked), 0);
    drive("ll.reseed8", 0, 1, 0, 0);
    chk("ll.relocked", int'(locked), 1);
    drive("wr.rst", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive("wr.seed", 0, 1, 0, 0);
    for (int i = 0; i < 32; i++) drive("wr.bits", 0, 1, i >= 13 && i <= 18, 0);
    chk("wr.locked", int'(locked), 1);
    chk("wr.err_cnt", int'(err_cnt), CNT_ON ? 6 : 0);
    for (int i = 0; i < 16; i++) drive("pr.bits", 0, 1, i >= 12, 0);
    chk("pr.lost_on_last", int'(locked), 0);
    for (int i = 0; i < 12; i++) drive("gap.pre", 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive("gap.idle", 0, 0, 0, 0);
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      drive("gap.post", 0, 1, 0, 0);
      errs += int'(err);
    end
    chk("gap.errors", errs, 0);
    chk("gap.locked", int'(locked), 1);
`ifdef PRBS_CHECKER_ERRCNT_EN
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 65535;
    drive("sat.inject", 0, 1, 1, 0);
    chk("sat.held", int'(err_cnt), 65535);
`endif
    drive("clr.inject", 0, 1, 1, 1);
    chk("clr.err", int'(err), 1);
    chk("clr.cnt", int'(err_cnt), 0);
    drive("mr.rst", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive("mr.seed", 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive("mr.bits", 0, 1, i == 5, 0);
    drive("mr.rst2", 1, 0, 0, 0);
    chk("mr.locked", int'(locked), 0);
    chk("mr.cnt", int'(err_cnt), 0);
    for (int i = 0; i < 8; i++) drive("mr.reseed", 0, 1, 0, 0);
    chk("mr.relocked", int'(locked), 1);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = $urandom_range(0, 499) == 0;
      tap = ($urandom_range(0, 9) == 0) ? 8'($urandom) : g_tap;
      drive("rnd", r, !r && $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 4, $urandom_range(0, 49) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter WIN, default 16: size of the lock-supervision window, in accepted bits (range 2..256).
REQ-002 Parameter ERR_THRESH, default 4: error count within one window that forces loss of lock (range 1..WIN).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tap  input  8  feedback tap mask, same convention as the team's 8-bit LFSR generator.
REQ-006 bit_in  input  1  received serial bit, equal to the generator's newly shifted-in LSB.
REQ-007 bit_vld  input  1  bit_in qualifier; bits are accepted only when high.
REQ-008 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 locked  output  1  high while in CHECK state.
REQ-010 err  output  1  registered one-cycle pulse marking a mismatched bit.
REQ-011 err_cnt  output  16  saturating count of mismatched bits.

Function
REQ-012 The checker SHALL implement two states, SEED and CHECK, and SHALL hold an 8-bit shadow register, a 3-bit seed count, a window bit count and a window error count.
REQ-013 In SEED, each accepted bit SHALL shift as shadow <= {shadow[6:0], bit_in} and SHALL increment seed count; no comparison is made and err stays 0.
REQ-014 On the 8th accepted bit in SEED, the checker SHALL enter CHECK, capture tap into tap_q, and clear the window counters; locked SHALL be high from the next cycle.
REQ-015 In CHECK, for each accepted bit, exp = XOR-reduce(shadow & tap_q); shadow <= {shadow[6:0], exp}, so the checker is free-running and not self-synchronising.
REQ-016 In CHECK, err SHALL be 1 in the cycle after an accepted bit with bit_in != exp, and 0 otherwise.
REQ-017 Cycles with bit_vld low SHALL leave the shadow register, all counters and the state unchanged, and SHALL force err to 0 in the following cycle.
REQ-018 The window bit count SHALL wrap from WIN-1 to 0; at the wrap, the window error count SHALL reset to 0 after including the current bit.
REQ-019 When the window error count, including the current bit, reaches ERR_THRESH, the checker SHALL return to SEED with seed count 0; locked SHALL fall in the next cycle.
REQ-020 When the threshold is reached on the last bit of a window, loss of lock SHALL take priority over the window wrap.
REQ-021 tap changes during CHECK SHALL be ignored until the next SEED-to-CHECK transition.
REQ-022 err_cnt SHALL increment in the same cycle that err asserts, and SHALL saturate at 16'hFFFF.
REQ-023 When clr_cnt is high, err_cnt SHALL become 0; clr_cnt SHALL win over a simultaneous increment, while the err pulse is still produced.
REQ-024 An all-zero shadow register with any tap SHALL be checked normally, predicting all zeros; no special case applies.

Reset
REQ-025 While reset is high, the checker SHALL enter SEED and set shadow=0, seed count=0, window counts=0, tap_q=0, locked=0, err=0 and err_cnt=0.
REQ-026 Reset asserted mid-CHECK or mid-SEED SHALL abort the operation in progress; the next accepted bit after reset releases is seed bit 1.

Configuration
REQ-027 Macro PRBS_CHECKER_ERRCNT_EN SHALL control the err_cnt feature.
REQ-028 With PRBS_CHECKER_ERRCNT_EN defined, err_cnt and clr_cnt SHALL behave per REQ-022 and REQ-023.
REQ-029 Without PRBS_CHECKER_ERRCNT_EN, the counter SHALL NOT be built: err_cnt is tied to 16'h0000 and clr_cnt is ignored, while err and locked are unchanged.

Verification
REQ-030 Seed: tap=8'hB8, bits 1,0,1,1,0,0,1,0 with bit_vld high -> shadow=8'hB2, locked=1 one cycle after the 8th bit, err=0 throughout.
REQ-031 Prediction: continue from REQ-030 with bit_in=1 -> no error (exp = XOR-reduce(8'hB0) = 1), shadow=8'h65; bit_in=0 instead -> err pulses once and err_cnt=1.
REQ-032 Lock loss: WIN=16, ERR_THRESH=4, locked; 4 inverted bits inside one window -> locked falls the cycle after the 4th err, and the next 8 bits reseed.
REQ-033 Window wrap: 3 errors in window 0 and 3 errors in window 1 -> locked stays 1 and err_cnt=6.
REQ-034 Boundaries: preload err_cnt to 16'hFFFF, then inject an error -> err_cnt stays 16'hFFFF; clr_cnt together with an error -> err_cnt=0 and err=1; bit_vld low for 5 cycles mid-stream -> no errors, stream resumes in phase.
REQ-035 Reset mid-CHECK after 20 bits -> locked=0 and err_cnt=0 the next cycle; 8 new bits -> locked=1.
